// File: rtl/sdio_clk_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdio_clk_ctrl
// Purpose  : Sequencing controller for the SD card clock generator. Owns the
//            generator enable, divider and pause inputs. Software enable and
//            divider changes are applied glitch-free: wait for the bus to go
//            idle, stop the clock low, load the divider, restart. Also issues
//            the card-initialisation clock burst and pauses the SD clock
//            (only while it is low) when the data buffers stall.
// Ports    : sd_clk, rstn             - system clock, async active-low reset
//            cfg_clk_en/div/div_wr    - software enable, divider, write strobe
//            init_start               - strobe: issue initialisation burst
//            cmd_active, dat_active   - bus busy indicators
//            dat_tx_stall/rx_stall    - data buffer stall requests
//            clk_o_i/clk_oe_i/clk_rise_i - generator status
//            sd_clk_en/div/pause      - generator controls (registered)
//            clk_ready, div_busy, init_done - status (registered)
// Revision : 1.0 - initial release
// ============================================================================
module sdio_clk_ctrl #(
    parameter logic [7:0] DIV_RST   = 8'd124,
    parameter int         INIT_CLKS = 80
) (
    input  logic       sd_clk,
    input  logic       rstn,
    input  logic       cfg_clk_en,
    input  logic [7:0] cfg_clk_div,
    input  logic       cfg_div_wr,
    input  logic       init_start,
    input  logic       cmd_active,
    input  logic       dat_active,
    input  logic       dat_tx_stall,
    input  logic       dat_rx_stall,
    input  logic       clk_o_i,
    input  logic       clk_oe_i,
    input  logic       clk_rise_i,
    output logic       sd_clk_en,
    output logic [7:0] sd_clk_div,
    output logic       sd_clk_pause,
    output logic       clk_ready,
    output logic       div_busy,
    output logic       init_done
);

    localparam int                 c_cnt_w     = $clog2(INIT_CLKS + 1);
    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_CLKS);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_INIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_STOP  = 3'd4,
        ST_UPD   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;

    logic [7:0]         r_pend_div;
    logic               r_div_pend;
    logic [c_cnt_w-1:0] r_init_cnt;
    logic               r_clk_en;
    logic [7:0]         r_clk_div;
    logic               r_pause;
    logic               r_ready;
    logic               r_busy;
    logic               r_init_done;

    logic [7:0]         w_nxt_pend_div;
    logic               w_nxt_div_pend;
    logic [c_cnt_w-1:0] w_nxt_init_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [7:0]         w_nxt_clk_div;
    logic               w_nxt_init_done;
    logic               w_nxt_clk_en;
    logic               w_nxt_pause;
    logic               w_nxt_ready;
    logic               w_nxt_busy;

    // ------------------------------------------------------------------------
    // State and output registers. Every output is the registered copy of a
    // value derived from the next state, so outputs change together with the
    // state they belong to.
    // ------------------------------------------------------------------------
    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_OFF;
            r_pend_div  <= 8'd0;
            r_div_pend  <= 1'b0;
            r_init_cnt  <= '0;
            r_clk_en    <= 1'b0;
            r_clk_div   <= DIV_RST;
            r_pause     <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_pend_div  <= w_nxt_pend_div;
            r_div_pend  <= w_nxt_div_pend;
            r_init_cnt  <= w_nxt_init_cnt;
            r_clk_en    <= w_nxt_clk_en;
            r_clk_div   <= w_nxt_clk_div;
            r_pause     <= w_nxt_pause;
            r_ready     <= w_nxt_ready;
            r_busy      <= w_nxt_busy;
            r_init_done <= w_nxt_init_done;
        end
    end

    assign w_cnt_inc = r_init_cnt + {{(c_cnt_w-1){1'b0}}, clk_rise_i};

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pend_div  = r_pend_div;
        w_nxt_div_pend  = r_div_pend;
        w_nxt_init_cnt  = r_init_cnt;
        w_nxt_clk_div   = r_clk_div;
        w_nxt_init_done = r_init_done;

        // Writes arriving while the clock may be running are parked; the
        // newest write overwrites any older parked value.
        if (cfg_div_wr && (r_state != ST_OFF) && (r_state != ST_UPD)) begin
            w_nxt_pend_div = cfg_clk_div;
            w_nxt_div_pend = 1'b1;
        end

        case (r_state)
            ST_OFF: begin
                // Clock is stopped, so the divider can be loaded directly.
                if (cfg_div_wr) begin
                    w_nxt_clk_div = cfg_clk_div;
                end
                if (cfg_clk_en) begin
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // A configuration change takes priority over an init burst.
                if (r_div_pend || !cfg_clk_en || cfg_div_wr) begin
                    w_nxt_state = ST_DRAIN;
                end else if (init_start) begin
                    w_nxt_state     = ST_INIT;
                    w_nxt_init_done = 1'b0;
                    w_nxt_init_cnt  = '0;
                end
            end
            ST_INIT: begin
                if (!cfg_clk_en) begin
                    w_nxt_state = ST_DRAIN;
                end else begin
                    w_nxt_init_cnt = w_cnt_inc;
                    if (w_cnt_inc == c_init_last) begin
                        w_nxt_init_done = 1'b1;
                        w_nxt_state     = r_div_pend ? ST_DRAIN : ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!cmd_active && !dat_active) begin
                    w_nxt_state = ST_STOP;
                end
            end
            ST_STOP: begin
                // The generator finishes its high phase before dropping OE,
                // so OE low means the clock is parked low.
                if (!clk_oe_i) begin
                    w_nxt_state = ST_UPD;
                end
            end
            ST_UPD: begin
                if (cfg_div_wr) begin
                    w_nxt_clk_div = cfg_clk_div;
                end else if (r_div_pend) begin
                    w_nxt_clk_div = r_pend_div;
                end
                w_nxt_div_pend = 1'b0;
                w_nxt_state    = cfg_clk_en ? ST_RUN : ST_OFF;
            end
            default: begin
                w_nxt_state = ST_OFF;
            end
        endcase

        if (w_nxt_state == ST_OFF) begin
            w_nxt_init_done = 1'b0;
        end

        w_nxt_clk_en = (w_nxt_state == ST_RUN) || (w_nxt_state == ST_INIT) ||
                       (w_nxt_state == ST_DRAIN);

        w_nxt_ready  = (w_nxt_state == ST_RUN) && clk_oe_i && !w_nxt_div_pend;

        w_nxt_busy   = w_nxt_div_pend || (w_nxt_state == ST_DRAIN) ||
                       (w_nxt_state == ST_STOP) || (w_nxt_state == ST_UPD);

        // A new pause may only start in a low-phase cycle that is not about
        // to rise, so the clock always freezes low. Once set it holds for as
        // long as the stall persists without command traffic.
        w_nxt_pause  = ((w_nxt_state == ST_RUN) || (w_nxt_state == ST_DRAIN)) &&
                       (dat_tx_stall || dat_rx_stall) && !cmd_active &&
                       (r_pause || (!clk_o_i && !clk_rise_i));
    end

    assign sd_clk_en    = r_clk_en;
    assign sd_clk_div   = r_clk_div;
    assign sd_clk_pause = r_pause;
    assign clk_ready    = r_ready;
    assign div_busy     = r_busy;
    assign init_done    = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_sdio_clk_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sdio_clk_ctrl
// Purpose  : Self-checking bench for sdio_clk_ctrl. Contains a behavioural SD
//            clock generator, a pause-condition vector table, directed
//            sequences and randomized traffic checked against a last-write
//            divider model plus clock-safety monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdio_clk_ctrl;

    logic       sd_clk = 1'b0;
    logic       rstn   = 1'b0;
    logic       cfg_clk_en, cfg_div_wr, init_start;
    logic [7:0] cfg_clk_div;
    logic       cmd_active, dat_active, dat_tx_stall, dat_rx_stall;
    logic       clk_o_i, clk_oe_i, clk_rise_i;
    logic       sd_clk_en, sd_clk_pause, clk_ready, div_busy, init_done;
    logic [7:0] sd_clk_div;

    // Generator model or direct drive of the generator status inputs
    logic       use_gen;
    logic       drv_o, drv_oe, drv_rise;
    logic       gen_o, gen_oe, gen_rise;
    logic [7:0] gen_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       mon_en = 1'b0;
    logic       watch5 = 1'b0;
    logic       saw5   = 1'b0;
    logic       prev_o, prev_rise, prev_pause;
    logic [7:0] prev_div;
    logic [7:0] last_div;

    always #5 sd_clk = ~sd_clk;
    always @(posedge sd_clk) cyc <= cyc + 1;

    sdio_clk_ctrl #(.DIV_RST(8'd124), .INIT_CLKS(80)) dut (
        .sd_clk       (sd_clk),
        .rstn         (rstn),
        .cfg_clk_en   (cfg_clk_en),
        .cfg_clk_div  (cfg_clk_div),
        .cfg_div_wr   (cfg_div_wr),
        .init_start   (init_start),
        .cmd_active   (cmd_active),
        .dat_active   (dat_active),
        .dat_tx_stall (dat_tx_stall),
        .dat_rx_stall (dat_rx_stall),
        .clk_o_i      (clk_o_i),
        .clk_oe_i     (clk_oe_i),
        .clk_rise_i   (clk_rise_i),
        .sd_clk_en    (sd_clk_en),
        .sd_clk_div   (sd_clk_div),
        .sd_clk_pause (sd_clk_pause),
        .clk_ready    (clk_ready),
        .div_busy     (div_busy),
        .init_done    (init_done)
    );

    // Generator: high phase always completes; low phase counts only while
    // enabled and not paused; OE drops once disabled in the low phase.
    assign gen_rise = sd_clk_en && !sd_clk_pause && !gen_o && (gen_cnt == sd_clk_div);

    always @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            gen_o   <= 1'b0;
            gen_oe  <= 1'b0;
            gen_cnt <= 8'd0;
        end else if (gen_o) begin
            if (gen_cnt == sd_clk_div) begin
                gen_o   <= 1'b0;
                gen_cnt <= 8'd0;
            end else begin
                gen_cnt <= gen_cnt + 8'd1;
            end
        end else if (sd_clk_en) begin
            gen_oe <= 1'b1;
            if (!sd_clk_pause) begin
                if (gen_cnt == sd_clk_div) begin
                    gen_o   <= 1'b1;
                    gen_cnt <= 8'd0;
                end else begin
                    gen_cnt <= gen_cnt + 8'd1;
                end
            end
        end else begin
            gen_oe  <= 1'b0;
            gen_cnt <= 8'd0;
        end
    end

    assign clk_o_i    = use_gen ? gen_o    : drv_o;
    assign clk_oe_i   = use_gen ? gen_oe   : drv_oe;
    assign clk_rise_i = use_gen ? gen_rise : drv_rise;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Safety monitors: pause only starts from a low, non-rising cycle and
    // keeps the clock low; divider never changes while the clock is enabled.
    always @(negedge sd_clk) begin
        if (mon_en && rstn) begin
            if (sd_clk_pause && !prev_pause) begin
                chk("pause_start_low", 32'(prev_o | prev_rise), 32'd0);
            end
            if (sd_clk_pause && prev_pause) begin
                chk("pause_frozen_low", 32'(gen_o), 32'd0);
            end
            if (sd_clk_div != prev_div) begin
                chk("div_change_oe", 32'(gen_oe), 32'd0);
            end
            if (watch5 && sd_clk_div == 8'd5) saw5 = 1'b1;
        end
        prev_o     = clk_o_i;
        prev_rise  = clk_rise_i;
        prev_pause = sd_clk_pause;
        prev_div   = sd_clk_div;
    end

    task automatic wait_ready(input int bound, input string nm);
        for (int i = 0; i < bound; i++) begin
            if (clk_ready && !div_busy) break;
            @(negedge sd_clk);
        end
        chk(nm, 32'(clk_ready && !div_busy), 32'd1);
    endtask

    task automatic next_rise(output int t);
        t = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge sd_clk);
            if (clk_rise_i) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic write_div(input logic [7:0] d);
        cfg_clk_div = d;
        cfg_div_wr  = 1'b1;
        last_div    = d;
        @(negedge sd_clk);
        cfg_div_wr  = 1'b0;
    endtask

    typedef struct {
        logic tx;
        logic rx;
        logic cmd;
        logic o;
        logic rise;
        logic exp_pause;
    } pvec_t;

    pvec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t1, t2, n;
        bit  ok;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        cfg_clk_en = 0; cfg_div_wr = 0; init_start = 0; cfg_clk_div = 0;
        cmd_active = 0; dat_active = 0; dat_tx_stall = 0; dat_rx_stall = 0;
        use_gen = 0; drv_o = 0; drv_oe = 0; drv_rise = 0;
        last_div = 8'd124;

        // ---------------- reset state ----------------
        repeat (3) @(negedge sd_clk);
        chk("rst_en",    32'(sd_clk_en),    32'd0);
        chk("rst_div",   32'(sd_clk_div),   32'd124);
        chk("rst_pause", 32'(sd_clk_pause), 32'd0);
        chk("rst_ready", 32'(clk_ready),    32'd0);
        chk("rst_busy",  32'(div_busy),     32'd0);
        chk("rst_init",  32'(init_done),    32'd0);
        rstn = 1'b1;
        @(negedge sd_clk);

        // ---------------- direct-drive: OFF write, pause table ----------------
        write_div(8'd20);
        chk("off_wr_div", 32'(sd_clk_div), 32'd20);
        chk("off_en0",    32'(sd_clk_en),  32'd0);
        drv_oe = 1'b1;
        cfg_clk_en = 1'b1;
        @(negedge sd_clk);
        chk("run_en", 32'(sd_clk_en), 32'd1);
        @(negedge sd_clk);
        chk("run_ready", 32'(clk_ready), 32'd1);

        for (int v = 0; v < 8; v++) begin
            dat_tx_stall = tbl[v].tx;
            dat_rx_stall = tbl[v].rx;
            cmd_active   = tbl[v].cmd;
            drv_o        = tbl[v].o;
            drv_rise     = tbl[v].rise;
            @(negedge sd_clk);
            chk($sformatf("pause_vec%0d", v), 32'(sd_clk_pause), 32'(tbl[v].exp_pause));
            dat_tx_stall = 0; dat_rx_stall = 0; cmd_active = 0; drv_o = 0; drv_rise = 0;
            @(negedge sd_clk);
            if (tbl[v].exp_pause) chk($sformatf("pause_clr%0d", v), 32'(sd_clk_pause), 32'd0);
        end

        // ---------------- reset while in STOP ----------------
        write_div(8'd50);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (!sd_clk_en && div_busy) begin ok = 1; break; end
            @(negedge sd_clk);
        end
        chk("reach_stop", 32'(ok), 32'd1);
        chk("stop_div_held", 32'(sd_clk_div), 32'd20);
        #2 rstn = 1'b0;
        #1;
        chk("rst2_en",    32'(sd_clk_en),    32'd0);
        chk("rst2_div",   32'(sd_clk_div),   32'd124);
        chk("rst2_busy",  32'(div_busy),     32'd0);
        chk("rst2_ready", 32'(clk_ready),    32'd0);
        chk("rst2_pause", 32'(sd_clk_pause), 32'd0);
        cfg_clk_en = 1'b0; drv_oe = 1'b0; use_gen = 1'b1;
        @(negedge sd_clk);
        rstn = 1'b1;
        @(negedge sd_clk);
        mon_en = 1'b1;
        @(negedge sd_clk);

        // ---------------- divider 3 from OFF, period 8 ----------------
        write_div(8'd3);
        chk("div3_before_en", 32'(sd_clk_div), 32'd3);
        chk("en_still0",      32'(sd_clk_en),  32'd0);
        cfg_clk_en = 1'b1;
        @(negedge sd_clk);
        chk("en_rises", 32'(sd_clk_en), 32'd1);
        wait_ready(50, "ready_div3");
        next_rise(t1);
        next_rise(t2);
        chk("sd_clk_period", 32'(t2 - t1), 32'd8);

        // ---------------- change to div 0 held off by dat_active ----------------
        dat_active = 1'b1;
        write_div(8'd0);
        chk("drain_busy", 32'(div_busy), 32'd1);
        repeat (10) @(negedge sd_clk);
        chk("drain_hold_en",  32'(sd_clk_en),  32'd1);
        chk("drain_hold_div", 32'(sd_clk_div), 32'd3);
        dat_active = 1'b0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (!sd_clk_en) begin ok = 1; break; end
            @(negedge sd_clk);
        end
        chk("stop_en_low", 32'(ok), 32'd1);
        wait_ready(100, "ready_div0");
        chk("div0_loaded", 32'(sd_clk_div), 32'd0);

        // ---------------- last write wins: 5 then 9 ----------------
        dat_active = 1'b1;
        watch5 = 1'b1;
        write_div(8'd5);
        repeat (3) @(negedge sd_clk);
        write_div(8'd9);
        repeat (3) @(negedge sd_clk);
        dat_active = 1'b0;
        wait_ready(100, "ready_div9");
        chk("div9_loaded", 32'(sd_clk_div), 32'd9);
        chk("div5_never",  32'(saw5),       32'd0);
        watch5 = 1'b0;

        // ---------------- init burst at div 124 ----------------
        write_div(8'd124);
        wait_ready(200, "ready_div124");
        chk("div124_loaded", 32'(sd_clk_div), 32'd124);
        init_start = 1'b1;
        @(negedge sd_clk);
        init_start = 1'b0;
        n = 0;
        for (int i = 0; i < 25000; i++) begin
            if (init_done) break;
            n += int'(clk_rise_i);
            @(negedge sd_clk);
        end
        chk("init_rises", 32'(n), 32'd80);
        chk("init_done",  32'(init_done), 32'd1);
        chk("init_idle",  32'(div_busy),  32'd0);

        // aborted burst
        init_start = 1'b1;
        @(negedge sd_clk);
        init_start = 1'b0;
        chk("init_clear", 32'(init_done), 32'd0);
        n = 0;
        for (int i = 0; i < 12000; i++) begin
            n += int'(clk_rise_i);
            if (n == 40) break;
            @(negedge sd_clk);
        end
        cfg_clk_en = 1'b0;
        @(negedge sd_clk);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (!div_busy) begin ok = 1; break; end
            @(negedge sd_clk);
        end
        chk("abort_settled", 32'(ok),        32'd1);
        chk("abort_init0",   32'(init_done), 32'd0);
        chk("abort_off_en",  32'(sd_clk_en), 32'd0);
        chk("abort_off_rdy", 32'(clk_ready), 32'd0);

        // ---------------- pause behaviour ----------------
        write_div(8'd3);
        cfg_clk_en = 1'b1;
        wait_ready(50, "ready_pause");
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (clk_o_i) begin ok = 1; break; end
            @(negedge sd_clk);
        end
        chk("saw_clk_high", 32'(ok), 32'd1);
        dat_rx_stall = 1'b1;
        @(negedge sd_clk);
        chk("no_pause_high", 32'(sd_clk_pause), 32'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (sd_clk_pause) begin ok = 1; break; end
            @(negedge sd_clk);
        end
        chk("pause_set", 32'(ok), 32'd1);
        ok = 1;
        repeat (16) begin
            @(negedge sd_clk);
            if (clk_o_i || clk_rise_i || !sd_clk_pause) ok = 0;
        end
        chk("pause_hold_low", 32'(ok), 32'd1);
        dat_rx_stall = 1'b0;
        @(negedge sd_clk);
        chk("pause_release", 32'(sd_clk_pause), 32'd0);
        cmd_active = 1'b1;
        dat_rx_stall = 1'b1;
        ok = 1;
        repeat (40) begin
            @(negedge sd_clk);
            if (sd_clk_pause) ok = 0;
        end
        chk("no_pause_cmd", 32'(ok), 32'd1);
        cmd_active = 1'b0;
        dat_rx_stall = 1'b0;
        @(negedge sd_clk);

        // ---------------- randomized traffic vs last-write model ----------------
        for (int ep = 0; ep < 25; ep++) begin
            for (int c = 0; c < 120; c++) begin
                if (clk_ready && !div_busy)
                    chk("rand_ready_div", 32'(sd_clk_div), 32'(last_div));
                cmd_active   = ($urandom_range(3, 0) == 0);
                dat_active   = ($urandom_range(2, 0) == 0);
                dat_tx_stall = ($urandom_range(7, 0) == 0);
                dat_rx_stall = ($urandom_range(7, 0) == 0);
                if ($urandom_range(49, 0) == 0) cfg_clk_en = ~cfg_clk_en;
                cfg_div_wr = ($urandom_range(15, 0) == 0);
                if (cfg_div_wr) begin
                    cfg_clk_div = 8'($urandom_range(5, 0));
                    last_div    = cfg_clk_div;
                end
                @(negedge sd_clk);
            end
            cfg_div_wr = 0; cmd_active = 0; dat_active = 0;
            dat_tx_stall = 0; dat_rx_stall = 0; cfg_clk_en = 1'b1;
            wait_ready(300, "rand_settle");
            chk("rand_settle_div", 32'(sd_clk_div), 32'(last_div));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
